// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating MEM and IF load/store requests
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [1:0]            memctl_op,
    input  logic [1:0]            memctl_len,
    input  logic [ADDR_WIDTH-1:0] memctl_addr,
    input  logic [31:0]           memctl_data,
    output logic                  memctl_fin,
    output logic [31:0]           memctl_out,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_fin,
    output logic [31:0]           if_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SAVE = 2'b10;

    state_t                state;
    logic                  client_if;
    logic [2:0]            nbytes;
    logic [2:0]            cnt;
    logic [2:0]            cnt_inc;
    logic [1:0]            cap_idx;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [31:0]           rbuf;
    logic [31:0]           rbuf_next;
    logic                  wr_q;
    logic                  mfin_q;
    logic                  ifin_q;
    logic [7:0]            held_din;
    logic                  held_valid;
    logic [7:0]            din_src;

    // Strobes are qualified so a paused or resetting cycle never writes RAM or signals completion.
    assign mem_wr     = wr_q & rdy_in & ~rst_in;
    assign memctl_fin = mfin_q & rdy_in & ~rst_in;
    assign if_fin     = ifin_q & rdy_in & ~rst_in;

    // The RAM keeps reading during a pause, so the byte due at the pause is kept aside.
    always_comb begin
        cnt_inc   = cnt + 3'd1;
        cap_idx   = 2'(cnt - 3'd1);
        din_src   = held_valid ? held_din : mem_din;
        rbuf_next = rbuf;
        rbuf_next[{cap_idx, 3'b000} +: 8] = din_src;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            client_if  <= 1'b0;
            nbytes     <= 3'd0;
            cnt        <= 3'd0;
            base       <= '0;
            wdata      <= 32'd0;
            rbuf       <= 32'd0;
            wr_q       <= 1'b0;
            mfin_q     <= 1'b0;
            ifin_q     <= 1'b0;
            held_din   <= 8'd0;
            held_valid <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= 8'd0;
            memctl_out <= 32'd0;
            if_out     <= 32'd0;
        end else if (!rdy_in) begin
            if (!held_valid) begin
                held_din   <= mem_din;
                held_valid <= 1'b1;
            end
        end else begin
            held_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= 3'd0;
                    rbuf <= 32'd0;
                    if (memctl_op == OP_LOAD || memctl_op == OP_SAVE) begin
                        client_if <= 1'b0;
                        base      <= memctl_addr;
                        wdata     <= memctl_data;
                        mem_a     <= memctl_addr;
                        nbytes    <= (memctl_len == 2'b00) ? 3'd1 :
                                     (memctl_len == 2'b01) ? 3'd2 : 3'd4;
                        if (memctl_op == OP_SAVE) begin
                            state    <= WRITE;
                            mem_dout <= memctl_data[7:0];
                            wr_q     <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end else if (if_req) begin
                        client_if <= 1'b1;
                        base      <= if_addr;
                        mem_a     <= if_addr;
                        nbytes    <= 3'd4;
                        state     <= READ;
                    end
                end
                READ: begin
                    cnt <= cnt_inc;
                    if (cnt != 3'd0)
                        rbuf <= rbuf_next;
                    if (cnt_inc < nbytes)
                        mem_a <= base + ADDR_WIDTH'(cnt_inc);
                    if (cnt == nbytes) begin
                        state <= DONE;
                        if (client_if) begin
                            if_out <= rbuf_next;
                            ifin_q <= 1'b1;
                        end else begin
                            memctl_out <= rbuf_next;
                            mfin_q     <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_inc < nbytes) begin
                        cnt      <= cnt_inc;
                        mem_a    <= base + ADDR_WIDTH'(cnt_inc);
                        mem_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
                    end else begin
                        wr_q   <= 1'b0;
                        mfin_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    mfin_q <= 1'b0;
                    ifin_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed bench for mem_ctrl checked every cycle against a phase-level model
module tb_mem_ctrl;
    localparam int MAXC    = 112;
    localparam int END_CYC = 105;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [1:0]  memctl_op;
    logic [1:0]  memctl_len;
    logic [31:0] memctl_addr;
    logic [31:0] memctl_data;
    logic        memctl_fin;
    logic [31:0] memctl_out;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_fin;
    logic [31:0] if_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
        .memctl_data(memctl_data), .memctl_fin(memctl_fin), .memctl_out(memctl_out),
        .if_req(if_req), .if_addr(if_addr), .if_fin(if_fin), .if_out(if_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // Stimulus tables indexed by cycle number.
    logic [1:0]  s_op     [MAXC];
    logic [1:0]  s_len    [MAXC];
    logic [31:0] s_addr   [MAXC];
    logic [31:0] s_data   [MAXC];
    logic        s_ifreq  [MAXC];
    logic [31:0] s_ifaddr [MAXC];
    logic        s_rdy    [MAXC];
    logic        s_rst    [MAXC];

    // Expected outputs per cycle, filled by the model.
    logic        e_mfin [MAXC];
    logic        e_ifin [MAXC];
    logic        e_wr   [MAXC];
    logic        e_av   [MAXC];
    logic [31:0] e_a    [MAXC];
    logic        e_mov  [MAXC];
    logic [31:0] e_mo   [MAXC];
    logic        e_iov  [MAXC];
    logic [31:0] e_io   [MAXC];

    // Physical RAM (low 16 address bits; test addresses never alias) and the model's copy.
    logic [7:0] ram     [65536];
    logic [7:0] ref_ram [65536];

    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] cur_mo = 32'd0;
    logic [31:0] cur_io = 32'd0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr)
            ram[mem_a[15:0]] <= mem_dout;
    end

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic drive(input int c);
        rst_in      = s_rst[c];
        rdy_in      = s_rdy[c];
        memctl_op   = s_op[c];
        memctl_len  = s_len[c];
        memctl_addr = s_addr[c];
        memctl_data = s_data[c];
        if_req      = s_ifreq[c];
        if_addr     = s_ifaddr[c];
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] v);
        ram[a[15:0]]     = v;
        ref_ram[a[15:0]] = v;
    endtask

    // A transaction is a list of phases; each phase takes one cycle and only advances when rdy is high.
    task automatic add_txn(input int c0, input bit is_if, input bit save, input logic [1:0] len,
                           input logic [31:0] base, input logic [31:0] data, output int nxt);
        int          n;
        int          last;
        int          p;
        int          t;
        logic [31:0] val;
        logic [31:0] ad;
        n    = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        last = save ? n + 1 : n + 2;
        if (is_if) begin
            s_ifreq[c0]  = 1'b1;
            s_ifaddr[c0] = base;
        end else begin
            s_op[c0]   = save ? 2'b10 : 2'b01;
            s_len[c0]  = len;
            s_addr[c0] = base;
            s_data[c0] = data;
        end
        val = 32'd0;
        for (int i = 0; i < n; i++) begin
            ad = base + 32'(i);
            val[8*i +: 8] = ref_ram[ad[15:0]];
        end
        p   = 1;
        t   = c0 + 1;
        nxt = 0;
        while (nxt == 0 && t < MAXC - 1) begin
            if (p == last && !save) begin
                if (is_if) begin e_iov[t] = 1'b1; e_io[t] = val; end
                else       begin e_mov[t] = 1'b1; e_mo[t] = val; end
            end
            if (s_rst[t]) begin
                e_mov[t+1] = 1'b1; e_mo[t+1] = 32'd0;
                e_iov[t+1] = 1'b1; e_io[t+1] = 32'd0;
                e_av[t+1]  = 1'b1; e_a[t+1]  = 32'd0;
                nxt = t + 1;
            end else begin
                if (p <= (save ? n : n + 1)) begin
                    e_av[t] = 1'b1;
                    e_a[t]  = base + 32'((p - 1 < n - 1) ? p - 1 : n - 1);
                end
                if (save && p <= n && s_rdy[t]) begin
                    e_wr[t] = 1'b1;
                    ad = base + 32'(p - 1);
                    ref_ram[ad[15:0]] = data[8*(p-1) +: 8];
                end
                if (p == last && s_rdy[t]) begin
                    if (is_if) e_ifin[t] = 1'b1;
                    else       e_mfin[t] = 1'b1;
                end
                if (s_rdy[t]) begin
                    if (p == last) nxt = t + 1;
                    p++;
                end
                t++;
            end
        end
        if (nxt == 0) nxt = MAXC - 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (cyc >= 3 && cyc < MAXC) begin
            if (e_mov[cyc]) cur_mo = e_mo[cyc];
            if (e_iov[cyc]) cur_io = e_io[cyc];
            chk("memctl_fin", 32'(memctl_fin), 32'(e_mfin[cyc]));
            chk("if_fin", 32'(if_fin), 32'(e_ifin[cyc]));
            chk("mem_wr", 32'(mem_wr), 32'(e_wr[cyc]));
            chk("memctl_out", memctl_out, cur_mo);
            chk("if_out", if_out, cur_io);
            if (e_av[cyc]) chk("mem_a", mem_a, e_a[cyc]);
            case (cyc)
                3:  begin chk("lit_rst_a", mem_a, 32'h0); chk("lit_rst_mout", memctl_out, 32'h0);
                          chk("lit_rst_iout", if_out, 32'h0); chk("lit_rst_dout", 32'(mem_dout), 32'h0); end
                6:  chk("lit_lw_a0", mem_a, 32'h0000_1000);
                9:  chk("lit_lw_a3", mem_a, 32'h0000_1003);
                10: chk("lit_lw_nofin", 32'(memctl_fin), 32'h0);
                11: begin chk("lit_lw_out", memctl_out, 32'h4433_2211); chk("lit_lw_fin", 32'(memctl_fin), 32'h1); end
                15: chk("lit_sb_wr", 32'(mem_wr), 32'h1);
                16: begin chk("lit_sb_fin", 32'(memctl_fin), 32'h1); chk("lit_sb_out", memctl_out, 32'h4433_2211); end
                17: begin chk("lit_sb_ram20", 32'(ram[16'h0020]), 32'hEF); chk("lit_sb_ram21", 32'(ram[16'h0021]), 32'h7B); end
                23: begin chk("lit_sh_fin", 32'(memctl_fin), 32'h1); chk("lit_sh_iffin", 32'(if_fin), 32'h0); end
                30: begin chk("lit_if_fin", 32'(if_fin), 32'h1); chk("lit_if_out", if_out, 32'h4433_2211); end
                42: chk("lit_pause_nofin", 32'(memctl_fin), 32'h0);
                43: begin chk("lit_pause_fin", 32'(memctl_fin), 32'h1); chk("lit_pause_out", memctl_out, 32'h4433_2211); end
                50: chk("lit_rst_mid_out", memctl_out, 32'h0);
                51: begin chk("lit_rst_ram80", 32'(ram[16'h0080]), 32'h0D); chk("lit_rst_ram81", 32'(ram[16'h0081]), 32'hF0);
                          chk("lit_rst_ram82", 32'(ram[16'h0082]), 32'hD8); end
                55: chk("lit_lb_out", memctl_out, 32'h0000_00F0);
                61: chk("lit_lh_out", memctl_out, 32'h0000_BEEF);
                67: chk("lit_wrap_a2", mem_a, 32'h0000_0000);
                70: chk("lit_wrap_out", memctl_out, 32'hD4C3_B2A1);
                80: chk("lit_ifpause_fin", 32'(if_fin), 32'h1);
                97: chk("lit_sw_pause_out", memctl_out, 32'h0102_0304);
                default: ;
            endcase
        end
    end

    initial begin
        int nx;
        for (int c = 0; c < MAXC; c++) begin
            s_op[c] = 2'b00; s_len[c] = 2'b00; s_addr[c] = 32'd0; s_data[c] = 32'd0;
            s_ifreq[c] = 1'b0; s_ifaddr[c] = 32'd0; s_rdy[c] = 1'b1; s_rst[c] = (c < 3);
            e_mfin[c] = 1'b0; e_ifin[c] = 1'b0; e_wr[c] = 1'b0; e_av[c] = 1'b0; e_a[c] = 32'd0;
            e_mov[c] = 1'b0; e_mo[c] = 32'd0; e_iov[c] = 1'b0; e_io[c] = 32'd0;
        end
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = dflt(16'(i));
            ref_ram[i] = dflt(16'(i));
        end
        preset(32'h1000, 8'h11); preset(32'h1001, 8'h22);
        preset(32'h1002, 8'h33); preset(32'h1003, 8'h44);
        preset(32'hFFFF_FFFE, 8'hA1); preset(32'hFFFF_FFFF, 8'hB2);
        preset(32'h0000_0000, 8'hC3); preset(32'h0000_0001, 8'hD4);
        e_av[3] = 1'b1;
        for (int c = 20; c <= 24; c++) begin
            s_ifreq[c]  = 1'b1;
            s_ifaddr[c] = 32'h1000;
        end
        s_rdy[37] = 1'b0; s_rdy[38] = 1'b0; s_rdy[39] = 1'b0;
        s_rst[49] = 1'b1;
        s_rdy[79] = 1'b0;
        s_rdy[85] = 1'b0;

        add_txn(5,  1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          nx);
        add_txn(14, 1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'hDEAD_BEEF,  nx);
        add_txn(20, 1'b0, 1'b1, 2'b01, 32'h0000_0040, 32'h0000_BEEF,  nx);
        add_txn(nx, 1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          nx);
        add_txn(34, 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          nx);
        add_txn(46, 1'b0, 1'b1, 2'b10, 32'h0000_0080, 32'hCAFE_F00D,  nx);
        add_txn(52, 1'b0, 1'b0, 2'b00, 32'h0000_0081, 32'h0,          nx);
        add_txn(57, 1'b0, 1'b0, 2'b01, 32'h0000_0040, 32'h0,          nx);
        add_txn(64, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          nx);
        add_txn(73, 1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0,          nx);
        add_txn(83, 1'b0, 1'b1, 2'b11, 32'h0000_0100, 32'h0102_0304,  nx);
        add_txn(91, 1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          nx);

        drive(0);
        while (cyc < END_CYC) begin
            @(posedge clk_in);
            #1;
            drive(cyc);
        end
        @(posedge clk_in);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
